// File: rtl/traffic_phase_timer.sv
// Tick-driven phase countdown: load a duration, count accepted ticks, pulse expire.
// Define PHASE_TIMER_EDGE_EN to count only rising edges of tick (held ticks count once).
module traffic_phase_timer #(
    parameter int CNT_W   = 8,
    parameter int WARN_TH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             pause,
    input  logic             abort,
    output logic             busy,
    output logic [CNT_W-1:0] remaining,
    output logic             expire,
    output logic             warn
);

    // state | meaning
    // IDLE  | no countdown active, remaining = 0
    // RUN   | counting accepted ticks, remaining >= 1
    // DONE  | countdown finished, expire high for this one cycle
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] WARN_LIM = CNT_W'(WARN_TH);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             expire_q, expire_d;
    logic             etick;

`ifdef PHASE_TIMER_EDGE_EN
    logic tick_q, tick_d;

    always_comb begin
        tick_d = tick;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign etick = tick & ~tick_q;
`else
    assign etick = tick;
`endif

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (!abort && load) begin
                    if (load_val != '0) begin
                        state_d = ST_RUN;
                        rem_d   = load_val;
                    end else begin
                        state_d = ST_DONE;
                        rem_d   = '0;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
                end else if (load) begin
                    if (load_val != '0) begin
                        state_d = ST_RUN;
                        rem_d   = load_val;
                    end else begin
                        state_d = ST_DONE;
                        rem_d   = '0;
                    end
                end else if (etick && !pause) begin
                    if (rem_q == ONE) begin
                        state_d = ST_DONE;
                        rem_d   = '0;
                    end else if (rem_q != '0) begin
                        rem_d = rem_q - ONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                rem_d   = '0;
                if (!abort && load) begin
                    if (load_val != '0) begin
                        state_d = ST_RUN;
                        rem_d   = load_val;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = '0;
            end
        endcase
        // expire is a registered copy of "entering DONE" so it lines up with the DONE cycle
        expire_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            expire_q <= expire_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign warn      = (state_q == ST_RUN) && (rem_q <= WARN_LIM);
    assign remaining = rem_q;
    assign expire    = expire_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Self-checking bench for traffic_phase_timer: phase-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_traffic_phase_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       pause = 1'b0;
    logic       abort = 1'b0;
    logic       busy;
    logic [7:0] remaining;
    logic       expire;
    logic       warn;

    int n_cmp = 0;
    int n_bad = 0;

    traffic_phase_timer #(.CNT_W(8), .WARN_TH(3)) dut (
        .clk(clk), .reset(reset), .tick(tick), .load(load), .load_val(load_val),
        .pause(pause), .abort(abort), .busy(busy), .remaining(remaining),
        .expire(expire), .warn(warn)
    );

    always #5 clk = ~clk;

    // Reference model: a phase is either running with some ticks left, or not.
    // Finishing a phase (or loading a zero-length one) produces one expire cycle.
    int m_left = 0;
    bit m_active = 0;
    bit m_expire = 0;
    bit m_prev_tick = 0;

    always @(posedge clk or posedge reset) begin
        bit counts;
        if (reset) begin
            m_left = 0; m_active = 0; m_expire = 0; m_prev_tick = 0;
        end else begin
`ifdef PHASE_TIMER_EDGE_EN
            counts = tick && !m_prev_tick;
`else
            counts = tick;
`endif
            m_prev_tick = tick;
            m_expire = 0;
            if (abort) begin
                m_active = 0; m_left = 0;
            end else if (load) begin
                m_left = load_val;
                m_active = (load_val != 0);
                m_expire = (load_val == 0);
            end else if (m_active && counts && !pause) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_active = 0; m_expire = 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("model_remaining", remaining, m_left);
            chk("model_busy", busy, m_active);
            chk("model_expire", expire, m_expire);
            chk("model_warn", warn, (m_active && m_left <= 3) ? 1 : 0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_load(input int v);
        load = 1'b1; load_val = 8'(v);
        cyc();
        load = 1'b0;
    endtask

    task automatic tick_once();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
    endtask

    task automatic go_idle();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        cyc();
    endtask

    int held_exp;

    initial begin
        repeat (2) cyc();
        reset = 1'b0;
        cyc();
        chk("reset_remaining", remaining, 0);
        chk("reset_busy", busy, 0);
        chk("reset_expire", expire, 0);
        chk("reset_warn", warn, 0);

        // basic countdown of 3 with ticks spaced 50 clocks
        do_load(3);
        chk("basic_load_rem", remaining, 3);
        chk("basic_load_busy", busy, 1);
        chk("basic_load_warn", warn, 1);
        repeat (50) cyc();
        tick = 1'b1; cyc(); tick = 1'b0;
        chk("basic_rem_2", remaining, 2);
        repeat (50) cyc();
        tick = 1'b1; cyc(); tick = 1'b0;
        chk("basic_rem_1", remaining, 1);
        repeat (50) cyc();
        tick = 1'b1; cyc(); tick = 1'b0;
        chk("basic_expire", expire, 1);
        chk("basic_rem_0", remaining, 0);
        chk("basic_busy_done", busy, 0);
        cyc();
        chk("basic_expire_single", expire, 0);
        chk("basic_busy_idle", busy, 0);

        // zero-length load
        do_load(0);
        chk("zero_expire", expire, 1);
        chk("zero_busy", busy, 0);
        cyc();
        chk("zero_expire_gone", expire, 0);

        // reload mid-run
        do_load(6);
        tick_once();
        tick_once();
        chk("reload_rem_4", remaining, 4);
        do_load(10);
        chk("reload_rem_10", remaining, 10);
        chk("reload_no_expire", expire, 0);
        chk("reload_warn_low", warn, 0);
        go_idle();

        // pause swallows a tick; abort beats load
        do_load(5);
        pause = 1'b1; tick = 1'b1;
        cyc();
        pause = 1'b0; tick = 1'b0;
        chk("pause_rem_5", remaining, 5);
        abort = 1'b1; load = 1'b1; load_val = 8'd7;
        cyc();
        abort = 1'b0; load = 1'b0;
        chk("abort_rem", remaining, 0);
        chk("abort_busy", busy, 0);
        chk("abort_expire", expire, 0);
        cyc();
        chk("abort_expire_next", expire, 0);

        // tick coincident with load, then load during DONE
        tick = 1'b1;
        do_load(6);
        tick = 1'b0;
        chk("coinc_rem_6", remaining, 6);
        cyc();
        repeat (5) tick_once();
        chk("coinc_rem_1", remaining, 1);
        tick = 1'b1; cyc(); tick = 1'b0;
        chk("done_expire", expire, 1);
        do_load(2);
        chk("done_load_busy", busy, 1);
        chk("done_load_rem", remaining, 2);
        chk("done_load_expire_gone", expire, 0);
        go_idle();

        // held tick: counts once with edge detection, every cycle without
        do_load(5);
        tick = 1'b1;
        repeat (4) cyc();
        tick = 1'b0;
        cyc();
`ifdef PHASE_TIMER_EDGE_EN
        held_exp = 4;
`else
        held_exp = 1;
`endif
        chk("held_tick_rem", remaining, held_exp);
        go_idle();

        // asynchronous reset mid-run
        do_load(5);
        cyc();
        #2 reset = 1'b1;
        #1;
        chk("async_rst_rem", remaining, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_warn", warn, 0);
        chk("async_rst_expire", expire, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) begin
            cyc();
            chk("post_rst_no_expire", expire, 0);
        end
        chk("post_rst_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
